// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
// Ports: clk, reset (async active-low), Start, MDOp, A, B -> Busy, Done, DivByZero, HI, LO.
module mult_div_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ITER       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [1:0]            MDOp,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  Busy,
    output logic                  Done,
    output logic                  DivByZero,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]  count;
    logic           is_div;
    logic           neg_q;
    logic           neg_r;
    logic           dz;
    logic [W-1:0]   opnd;
    logic [2*W-1:0] acc;
    logic [W-1:0]   hi_q;
    logic [W-1:0]   lo_q;

    logic           load;
    logic           last;
    logic           sgn_op;
    logic           div_op;
    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;

    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_sh;
    logic [W:0]     div_diff;
    logic           div_ok;
    logic [2*W-1:0] div_next;
    logic [2*W-1:0] acc_next;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quot_fix;
    logic [W-1:0]   rem_fix;

    // A new request is accepted in IDLE and in FIN (back-to-back).
    assign load   = Start && (state != RUN);
    assign last   = (count == CW'(ITER - 1));
    assign sgn_op = ~MDOp[0];
    assign div_op = MDOp[1];
    assign a_neg  = sgn_op & A[W-1];
    assign b_neg  = sgn_op & B[W-1];
    assign a_mag  = a_neg ? -A : A;
    assign b_mag  = b_neg ? -B : B;

    // Shift-add: low half of acc holds the multiplier, consumed LSB first.
    assign mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, acc[W-1:1]};

    // Restoring divide: acc = {partial remainder, dividend/quotient bits}.
    assign div_sh   = acc[2*W-1:W-1];
    assign div_diff = div_sh - {1'b0, opnd};
    assign div_ok   = ~div_diff[W];
    assign div_next = {div_ok ? div_diff[W-1:0] : div_sh[W-1:0],
                       acc[W-2:0], div_ok};

    assign acc_next = is_div ? div_next : mul_next;

    // Sign correction applied once, on the final iteration.
    assign prod_fix = neg_q ? -acc_next : acc_next;
    assign quot_fix = neg_q ? -acc_next[W-1:0] : acc_next[W-1:0];
    assign rem_fix  = neg_r ? -acc_next[2*W-1:W] : acc_next[2*W-1:W];

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (Start) state_next = RUN;
            RUN:     if (last) state_next = FIN;
            FIN:     state_next = Start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (load) begin
            count  <= '0;
            is_div <= div_op;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dz     <= div_op && (B == '0);
            opnd   <= div_op ? b_mag : a_mag;
            acc    <= {{W{1'b0}}, div_op ? a_mag : b_mag};
        end else if (state == RUN) begin
            count <= count + CW'(1);
            acc   <= acc_next;
            // Divide by zero leaves HI/LO untouched.
            if (last && !dz) begin
                if (is_div) begin
                    hi_q <= rem_fix;
                    lo_q <= quot_fix;
                end else begin
                    hi_q <= prod_fix[2*W-1:W];
                    lo_q <= prod_fix[W-1:0];
                end
            end
        end
    end

    assign Busy      = (state == RUN);
    assign Done      = (state == FIN);
    assign DivByZero = (state == FIN) && dz;
    assign HI        = hi_q;
    assign LO        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit.
// Drives hand-computed vectors and checks timing, HI/LO and flags.
module tb_mult_div_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [1:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic        DivByZero;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_tests = 0;
    int n_fail  = 0;

    mult_div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .MDOp      (MDOp),
        .A         (A),
        .B         (B),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero),
        .HI        (HI),
        .LO        (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive a request so it is sampled at the next edge (E0);
    // returns at the negedge inside cycle E0+1.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b);
        @(negedge clk);
        Start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        @(negedge clk);
        Start = 1'b0;
    endtask

    // Called in cycle E0+1; n is the number of cycles until Done.
    task automatic wait_done(input logic [31:0] hi0, input logic [31:0] lo0,
                             output int n, output int busy_n,
                             output bit stable, output bit done,
                             output bit dzf);
        n      = 0;
        busy_n = 0;
        stable = 1'b1;
        done   = 1'b0;
        dzf    = 1'b0;
        while (n < 40 && !done) begin
            if (Done) begin
                done = 1'b1;
                dzf  = DivByZero;
            end else begin
                if (Busy) busy_n++;
                if (HI !== hi0 || LO !== lo0) stable = 1'b0;
                n++;
                @(negedge clk);
            end
        end
    endtask

    task automatic finish_op(input string tag, input logic [31:0] hi0,
                             input logic [31:0] lo0,
                             input logic [31:0] ehi, input logic [31:0] elo,
                             input bit edz);
        int n;
        int bn;
        bit st;
        bit dn;
        bit dzf;
        wait_done(hi0, lo0, n, bn, st, dn, dzf);
        check({tag, " done"}, 64'(dn), 64'(1));
        check({tag, " latency"}, 64'(n), 64'(32));
        check({tag, " busy_cycles"}, 64'(bn), 64'(32));
        check({tag, " hilo_stable"}, 64'(st), 64'(1));
        check({tag, " busy_at_done"}, 64'(Busy), 64'(0));
        check({tag, " dz"}, 64'(dzf), 64'(edz));
        check({tag, " hi"}, 64'(HI), 64'(ehi));
        check({tag, " lo"}, 64'(LO), 64'(elo));
    endtask

    task automatic do_op(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input bit edz);
        logic [31:0] hi0;
        logic [31:0] lo0;
        hi0 = HI;
        lo0 = LO;
        start_op(op, a, b);
        finish_op(tag, hi0, lo0, ehi, elo, edz);
    endtask

    initial begin
        bit seen;
        reset = 1'b0;
        Start = 1'b0;
        MDOp  = 2'b00;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge clk);
        check("rst busy", 64'(Busy), 64'(0));
        check("rst done", 64'(Done), 64'(0));
        check("rst dz", 64'(DivByZero), 64'(0));
        check("rst hi", 64'(HI), 64'(0));
        check("rst lo", 64'(LO), 64'(0));
        reset = 1'b1;
        @(negedge clk);

        do_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'hFFFFFFFE, 32'h00000001, 1'b0);
        do_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd7,
              32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        do_op("mult_min", OP_MULT, 32'h80000000, 32'h80000000,
              32'h40000000, 32'h00000000, 1'b0);
        do_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2,
              32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        do_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        do_op("multu_5x6", OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);
        do_op("divu_zero", OP_DIVU, 32'd100, 32'd0, 32'd0, 32'd30, 1'b1);
        do_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF,
              32'h00000000, 32'h80000000, 1'b0);

        // Second Start mid-run with new operands must be ignored.
        start_op(OP_MULTU, 32'h00010000, 32'h00010000);
        fork
            begin
                repeat (3) @(negedge clk);
                Start = 1'b1;
                MDOp  = OP_DIVU;
                A     = 32'd7;
                B     = 32'd9;
                @(negedge clk);
                Start = 1'b0;
            end
        join_none
        finish_op("ignore_start", 32'h00000000, 32'h80000000,
                  32'h00000001, 32'h00000000, 1'b0);

        // Back-to-back: Start held during FIN.
        do_op("b2b_first", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        Start = 1'b1;
        MDOp  = OP_MULTU;
        A     = 32'd3;
        B     = 32'd4;
        @(negedge clk);
        Start = 1'b0;
        finish_op("b2b_second", 32'd2, 32'd14, 32'd0, 32'd12, 1'b0);

        // Asynchronous reset during RUN.
        start_op(OP_MULTU, 32'hFFFFFFFF, 32'd2);
        repeat (8) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst busy", 64'(Busy), 64'(0));
        check("arst done", 64'(Done), 64'(0));
        check("arst hi", 64'(HI), 64'(0));
        check("arst lo", 64'(LO), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Done || Busy) seen = 1'b1;
        end
        check("arst no_done", 64'(seen), 64'(0));
        do_op("post_rst", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
